// File: rtl/gpu_video_pkg.sv
// Shared timing constants and derived-constant helpers for the video timing generator.
package gpu_video_pkg;

    typedef struct packed {
        int h_fp;
        int h_sync;
        int h_bp;
        int h_act;
        int v_fp;
        int v_sync;
        int v_bp;
        int v_act;
    } video_mode_t;

    // 640x480 at 25.2 MHz (V_TOTAL 525) and the 25 MHz variant (V_TOTAL 521)
    localparam video_mode_t MODE_640X480_25M2 = '{32'sd16, 32'sd96, 32'sd48, 32'sd640,
                                                  32'sd10, 32'sd2,  32'sd33, 32'sd480};
    localparam video_mode_t MODE_640X480_25M  = '{32'sd16, 32'sd96, 32'sd48, 32'sd640,
                                                  32'sd10, 32'sd2,  32'sd29, 32'sd480};

    function automatic int act_start(input int fp, input int sync, input int bp);
        return fp + sync + bp;
    endfunction

    function automatic int total(input int fp, input int sync, input int bp, input int act);
        return act_start(fp, sync, bp) + act;
    endfunction

endpackage

// File: rtl/gpu_video_timing_axis.sv
// One timing axis: wrapping position counter plus combinational sync/active decode.
module gpu_video_axis
    import gpu_video_pkg::*;
#(
    parameter int CW   = 10,
    parameter int FP   = 16,
    parameter int SYNC = 96,
    parameter int BP   = 48,
    parameter int ACT  = 640,
    parameter bit POL  = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          sync,
    output logic          active,
    output logic [CW-1:0] rel
);

    localparam logic [CW-1:0] LAST_C    = CW'(total(FP, SYNC, BP, ACT) - 1);
    localparam logic [CW-1:0] SYNC_LO_C = CW'(FP);
    localparam logic [CW-1:0] SYNC_HI_C = CW'(FP + SYNC);
    localparam logic [CW-1:0] START_C   = CW'(act_start(FP, SYNC, BP));
    localparam logic [CW-1:0] ONE_C     = CW'(1);

    logic [CW-1:0] cnt_r;

    // Position counter, wraps to zero after the last active position
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (step) begin
            cnt_r <= (cnt_r == LAST_C) ? '0 : cnt_r + ONE_C;
        end
    end

    // Decode of the current position
    always_comb begin
        wrap   = step && (cnt_r == LAST_C);
        sync   = (cnt_r >= SYNC_LO_C && cnt_r < SYNC_HI_C) ? POL : ~POL;
        active = (cnt_r >= START_C);
        rel    = cnt_r - START_C;
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/gpu_video_timing.sv
// Video timing generator: raw counters, one-cycle-lagged registered decode, prefetch request.
module gpu_video_timing
    import gpu_video_pkg::*;
#(
    parameter int CW        = 10,
    parameter int H_FP      = MODE_640X480_25M2.h_fp,
    parameter int H_SYNC    = MODE_640X480_25M2.h_sync,
    parameter int H_BP      = MODE_640X480_25M2.h_bp,
    parameter int H_ACT     = MODE_640X480_25M2.h_act,
    parameter int V_FP      = MODE_640X480_25M2.v_fp,
    parameter int V_SYNC    = MODE_640X480_25M2.v_sync,
    parameter int V_BP      = MODE_640X480_25M2.v_bp,
    parameter int V_ACT     = MODE_640X480_25M2.v_act,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int REP_LOG2  = 0,
    parameter int LEAD      = 8,
    parameter int FCW       = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [CW-1:0]  x,
    output logic [CW-1:0]  y,
    output logic [CW-1:0]  hc,
    output logic [CW-1:0]  vc,
    output logic           line_start,
    output logic           frame_start,
    output logic           line_req,
    output logic [CW-1:0]  req_line,
    output logic [FCW-1:0] frame_cnt
);

    localparam int H_ACT_START = act_start(H_FP, H_SYNC, H_BP);
    localparam int H_TOTAL     = total(H_FP, H_SYNC, H_BP, H_ACT);
    localparam int V_TOTAL     = total(V_FP, V_SYNC, V_BP, V_ACT);

    if (LEAD < 1 || LEAD > H_ACT_START || REP_LOG2 < 0 || REP_LOG2 > 2 ||
        H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW)) begin : g_param_check
        $error("gpu_video_timing: illegal parameter set");
    end

    localparam logic [CW-1:0]  H_START_C = CW'(H_ACT_START);
    localparam logic [CW-1:0]  H_REQ_C   = CW'(H_ACT_START - LEAD);
    localparam logic [CW-1:0]  REP_MASK  = CW'((1 << REP_LOG2) - 1);
    localparam logic [FCW-1:0] FONE_C    = FCW'(1);

    logic [CW-1:0] h_cnt_s, v_cnt_s, h_rel_s, v_rel_s;
    logic          h_wrap_s, v_wrap_s, h_sync_s, v_sync_s, h_act_s, v_act_s;
    logic          req_hit_s;

    gpu_video_axis #(
        .CW(CW), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT), .POL(HSYNC_POL)
    ) u_h_axis (
        .clk(clk), .reset(reset), .step(en),
        .cnt(h_cnt_s), .wrap(h_wrap_s), .sync(h_sync_s), .active(h_act_s), .rel(h_rel_s)
    );

    gpu_video_axis #(
        .CW(CW), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT), .POL(VSYNC_POL)
    ) u_v_axis (
        .clk(clk), .reset(reset), .step(h_wrap_s),
        .cnt(v_cnt_s), .wrap(v_wrap_s), .sync(v_sync_s), .active(v_act_s), .rel(v_rel_s)
    );

    // Prefetch only on the first physical line of each repeated row group
    always_comb begin
        req_hit_s = (h_cnt_s == H_REQ_C) && v_act_s && ((v_rel_s & REP_MASK) == '0);
    end

    logic           hsync_r, vsync_r, de_r, ls_r, fs_r, lr_r;
    logic [CW-1:0]  x_r, y_r, req_line_r;
    logic [FCW-1:0] frame_cnt_r;

    // Registered decode; strobes drop to zero whenever timing is frozen
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_r     <= ~HSYNC_POL;
            vsync_r     <= ~VSYNC_POL;
            de_r        <= 1'b0;
            x_r         <= '0;
            y_r         <= '0;
            ls_r        <= 1'b0;
            fs_r        <= 1'b0;
            lr_r        <= 1'b0;
            req_line_r  <= '0;
            frame_cnt_r <= '0;
        end else if (en) begin
            hsync_r <= h_sync_s;
            vsync_r <= v_sync_s;
            de_r    <= h_act_s && v_act_s;
            x_r     <= (h_act_s && v_act_s) ? (h_rel_s >> REP_LOG2) : '0;
            y_r     <= v_act_s ? (v_rel_s >> REP_LOG2) : '0;
            ls_r    <= (h_cnt_s == H_START_C) && v_act_s;
            fs_r    <= (h_cnt_s == '0) && (v_cnt_s == '0);
            lr_r    <= req_hit_s;
            if (req_hit_s) begin
                req_line_r <= v_rel_s >> REP_LOG2;
            end
            if (v_wrap_s) begin
                frame_cnt_r <= frame_cnt_r + FONE_C;
            end
        end else begin
            ls_r <= 1'b0;
            fs_r <= 1'b0;
            lr_r <= 1'b0;
        end
    end

    assign hc          = h_cnt_s;
    assign vc          = v_cnt_s;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign de          = de_r;
    assign x           = x_r;
    assign y           = y_r;
    assign line_start  = ls_r;
    assign frame_start = fs_r;
    assign line_req    = lr_r;
    assign req_line    = req_line_r;
    assign frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_gpu_video_timing.sv
// Randomized bench for gpu_video_timing against a position-based reference model (small mode).
module tb_gpu_video_timing;

    localparam int CW = 8;
    localparam int H_FP = 3, H_SYNC = 4, H_BP = 5, H_ACT = 16;
    localparam int V_FP = 2, V_SYNC = 2, V_BP = 3, V_ACT = 8;
    localparam bit HP = 1'b0, VP = 1'b1;
    localparam int REP = 1, LEAD = 4, FCW = 3;
    localparam int HAS = H_FP + H_SYNC + H_BP, HT = HAS + H_ACT;
    localparam int VAS = V_FP + V_SYNC + V_BP, VT = VAS + V_ACT;

    logic clk = 1'b0;
    logic reset, en;
    logic hsync, vsync, de, line_start, frame_start, line_req;
    logic [CW-1:0] x, y, hc, vc, req_line;
    logic [FCW-1:0] frame_cnt;

    gpu_video_timing #(
        .CW(CW), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT),
        .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT),
        .HSYNC_POL(HP), .VSYNC_POL(VP), .REP_LOG2(REP), .LEAD(LEAD), .FCW(FCW)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .hsync(hsync), .vsync(vsync), .de(de),
        .x(x), .y(y), .hc(hc), .vc(vc), .line_start(line_start), .frame_start(frame_start),
        .line_req(line_req), .req_line(req_line), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: screen position plus the outputs implied by the previous position
    int mh, mv, mfc;
    bit e_hs, e_vs, e_de, e_ls, e_fs, e_lr;
    int e_x, e_y, e_rl;

    task automatic model_step(input bit r, input bit e);
        if (r) begin
            mh = 0; mv = 0; mfc = 0;
            e_hs = !HP; e_vs = !VP; e_de = 0; e_x = 0; e_y = 0;
            e_ls = 0; e_fs = 0; e_lr = 0; e_rl = 0;
        end else if (e) begin
            bit vact;
            vact = (mv >= VAS);
            e_hs = (mh >= H_FP && mh < H_FP + H_SYNC) ? HP : !HP;
            e_vs = (mv >= V_FP && mv < V_FP + V_SYNC) ? VP : !VP;
            e_de = (mh >= HAS) && vact;
            e_x  = e_de ? (mh - HAS) / (1 << REP) : 0;
            e_y  = vact ? (mv - VAS) / (1 << REP) : 0;
            e_ls = (mh == HAS) && vact;
            e_fs = (mh == 0) && (mv == 0);
            e_lr = (mh == HAS - LEAD) && vact && (((mv - VAS) % (1 << REP)) == 0);
            if (e_lr) e_rl = (mv - VAS) / (1 << REP);
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv++;
                if (mv == VT) begin
                    mv = 0;
                    mfc = (mfc + 1) % (1 << FCW);
                end
            end
        end else begin
            e_ls = 0; e_fs = 0; e_lr = 0;
        end
    endtask

    bit win_on = 0;
    int c_fs, c_de, c_ls, c_lr;

    task automatic compare_all();
        chk("hc", 32'(hc), 32'(mh));
        chk("vc", 32'(vc), 32'(mv));
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("de", 32'(de), 32'(e_de));
        chk("x", 32'(x), 32'(e_x));
        chk("y", 32'(y), 32'(e_y));
        chk("line_start", 32'(line_start), 32'(e_ls));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("line_req", 32'(line_req), 32'(e_lr));
        chk("req_line", 32'(req_line), 32'(e_rl));
        chk("frame_cnt", 32'(frame_cnt), 32'(mfc));
        if (win_on) begin
            c_fs += int'(frame_start);
            c_de += int'(de);
            c_ls += int'(line_start);
            c_lr += int'(line_req);
        end
    endtask

    task automatic cycle(input bit r, input bit e);
        @(negedge clk);
        compare_all();
        reset = r;
        en    = e;
        @(posedge clk);
        model_step(r, e);
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        repeat (3) begin
            @(posedge clk);
            model_step(1'b1, 1'b0);
        end

        // One full frame of enabled cycles with independent frame-level tallies
        cycle(1'b0, 1'b1);
        win_on = 1;
        for (int i = 0; i < VT * HT; i++) cycle(1'b0, 1'b1);
        win_on = 0;
        chk("frame_start_per_frame", 32'(c_fs), 32'd1);
        chk("de_per_frame", 32'(c_de), 32'(H_ACT * V_ACT));
        chk("line_start_per_frame", 32'(c_ls), 32'(V_ACT));
        chk("line_req_per_frame", 32'(c_lr), 32'(V_ACT >> REP));

        // Random enable gaps, rare mid-frame resets
        for (int i = 0; i < 5000; i++)
            cycle($urandom_range(0, 1499) == 0, $urandom_range(0, 7) != 0);

        // Long freeze mid-line
        for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 200; i++) cycle(1'b0, 1'b1);

        // Reset with en high at a chosen mid-frame position
        for (int i = 0; i < 2 * VT * HT && !(mv == 10 && mh == 20); i++) cycle(1'b0, 1'b1);
        chk("reached_reset_point", 32'(mv * HT + mh), 32'(10 * HT + 20));
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 3000; i++) cycle(1'b0, $urandom_range(0, 3) != 0);
        cycle(1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
